lvds_capture_ctrl: RTL and testbench

- Sequences one logic-analyzer capture from the deserialised LVDS sample stream (DataIN/StrobIN, registered on the LVDS capture clock) into a circular sample RAM.
- Flow: arm → pre-trigger fill → trigger search → post-trigger count → done.
- Generates RAM write strobes/addresses and reports trigger location for readout logic.
- Sits between the LVDS input stage and the sample buffer; configured by host-side control registers.

---
 rtl/lvds_capture_ctrl.sv | 157 +++++++++++++++
 tb/tb_lvds_capture_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_capture_ctrl.sv
// Capture sequencer for the LVDS logic analyser: arm, pre-trigger fill, trigger search,
// post-trigger count, done; drives the circular sample RAM write port.
module lvds_capture_ctrl #(
    parameter int unsigned LVDS_LEN = 8,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [LVDS_LEN-1:0] DataIN,
    input  logic                StrobIN,
    input  logic                Arm,
    input  logic                Abort,
    input  logic                ForceTrig,
    input  logic [LVDS_LEN-1:0] TrigMask,
    input  logic [LVDS_LEN-1:0] TrigValue,
    input  logic [ADDR_W-1:0]   PreLen,
    input  logic [ADDR_W-1:0]   PostLen,
    output logic                WrEn,
    output logic [ADDR_W-1:0]   WrAddr,
    output logic [LVDS_LEN-1:0] WrData,
    output logic                Busy,
    output logic                Triggered,
    output logic                Done,
    output logic [ADDR_W-1:0]   TrigAddr,
    output logic [ADDR_W-1:0]   StartAddr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_SEARCH = 3'd2,
        S_POST   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [LVDS_LEN-1:0] mask_q, value_q;
    logic [ADDR_W-1:0]   pre_q, post_q;
    logic [ADDR_W-1:0]   wr_ptr, count, count_inc;
    logic                accept, hit, arm_ok, count_clr, match;

    assign count_inc = count + ADDR_W'(1);
    assign match     = (((DataIN ^ value_q) & mask_q) == '0);

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-cycle control; Abort overrides everything
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hit       = 1'b0;
        arm_ok    = 1'b0;
        count_clr = 1'b0;
        if (Abort) begin
            state_nxt = S_IDLE;
            count_clr = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Arm) begin
                        arm_ok    = 1'b1;
                        count_clr = 1'b1;
                        state_nxt = (PreLen == '0) ? S_SEARCH : S_PRE;
                    end
                end
                S_PRE: begin
                    if (StrobIN) begin
                        accept = 1'b1;
                        if (count_inc == pre_q) begin
                            count_clr = 1'b1;
                            state_nxt = S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    if (StrobIN) begin
                        accept = 1'b1;
                        if (ForceTrig || match) begin
                            hit       = 1'b1;
                            count_clr = 1'b1;
                            state_nxt = (post_q == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (StrobIN) begin
                        accept = 1'b1;
                        if (count_inc == post_q) begin
                            count_clr = 1'b1;
                            state_nxt = S_DONE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: config latch, write port, counters, trigger bookkeeping
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            mask_q    <= '0;
            value_q   <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            Busy      <= 1'b0;
            Triggered <= 1'b0;
            Done      <= 1'b0;
            TrigAddr  <= '0;
            StartAddr <= '0;
        end else begin
            WrEn <= accept;
            Done <= (state_nxt == S_DONE);
            Busy <= (state_nxt == S_PRE) || (state_nxt == S_SEARCH) || (state_nxt == S_POST);

            if (accept) begin
                WrAddr <= wr_ptr;
                WrData <= DataIN;
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (count_clr)   count <= '0;
            else if (accept) count <= count_inc;

            if (arm_ok) begin
                mask_q    <= TrigMask;
                value_q   <= TrigValue;
                pre_q     <= PreLen;
                post_q    <= PostLen;
                wr_ptr    <= '0;
                Triggered <= 1'b0;
                TrigAddr  <= '0;
                StartAddr <= '0;
            end

            // Oldest retained sample sits PreLen slots behind the trigger, modulo DEPTH
            if (hit) begin
                Triggered <= 1'b1;
                TrigAddr  <= wr_ptr;
                StartAddr <= wr_ptr - pre_q;
            end

            if (Abort) Triggered <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// Self-checking bench for lvds_capture_ctrl (ADDR_W=4) against a sample-sequence reference model.
module tb_lvds_capture_ctrl;

    localparam int unsigned LW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          Clock;
    logic          Reset_n;
    logic [LW-1:0] DataIN;
    logic          StrobIN, Arm, Abort, ForceTrig;
    logic [LW-1:0] TrigMask, TrigValue;
    logic [AW-1:0] PreLen, PostLen;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [LW-1:0] WrData;
    logic          Busy, Triggered, Done;
    logic [AW-1:0] TrigAddr, StartAddr;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus stream (one entry per clock cycle after Arm)
    bit          stim_s[$];
    logic [7:0]  stim_d[$];
    bit          stim_f[$];
    bit          stim_a[$];

    // writes seen on the RAM port and writes the model expects
    logic [3:0]  got_addr[$];
    logic [7:0]  got_data[$];
    logic [3:0]  exp_addr[$];
    logic [7:0]  exp_data[$];

    bit          exp_trig, exp_done;
    int          exp_trig_cycle, exp_done_cycle;
    logic [3:0]  exp_trig_addr, exp_start;

    lvds_capture_ctrl #(.LVDS_LEN(LW), .ADDR_W(AW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .DataIN(DataIN), .StrobIN(StrobIN),
        .Arm(Arm), .Abort(Abort), .ForceTrig(ForceTrig),
        .TrigMask(TrigMask), .TrigValue(TrigValue), .PreLen(PreLen), .PostLen(PostLen),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy),
        .Triggered(Triggered), .Done(Done), .TrigAddr(TrigAddr), .StartAddr(StartAddr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (WrEn === 1'b1) begin
            got_addr.push_back(WrAddr);
            got_data.push_back(WrData);
        end
    end

    task automatic drive(input bit s, input logic [7:0] d, input bit f, input bit a, input bit ab);
        StrobIN = s; DataIN = d; ForceTrig = f; Arm = a; Abort = ab;
        @(posedge Clock); #1;
        StrobIN = 1'b0; ForceTrig = 1'b0; Arm = 1'b0; Abort = 1'b0;
    endtask

    task automatic stim_clear();
        stim_s.delete(); stim_d.delete(); stim_f.delete(); stim_a.delete();
    endtask

    task automatic stim_push(input bit s, input logic [7:0] d, input bit f, input bit a);
        stim_s.push_back(s); stim_d.push_back(d); stim_f.push_back(f); stim_a.push_back(a);
    endtask

    // Reference: walk the accepted samples; first PreLen fill, then the first match/force
    // triggers, then PostLen more; sample k lands at k mod DEPTH.
    task automatic run_model(input int pre, input int post, input logic [7:0] mask, input logic [7:0] value);
        int k = 0;
        int trig_k = -1;
        bit finished = 0;
        exp_addr.delete(); exp_data.delete();
        exp_trig = 0; exp_done = 0; exp_trig_cycle = 0; exp_done_cycle = 0;
        exp_trig_addr = '0; exp_start = '0;
        for (int c = 0; c < stim_s.size(); c++) begin
            if (stim_s[c] && !finished) begin
                exp_addr.push_back(4'(k % DEPTH));
                exp_data.push_back(stim_d[c]);
                if (trig_k < 0 && k >= pre && (stim_f[c] || ((stim_d[c] ^ value) & mask) == 8'h00)) begin
                    trig_k         = k;
                    exp_trig       = 1;
                    exp_trig_cycle = c;
                    exp_trig_addr  = 4'(k % DEPTH);
                    exp_start      = 4'((((k - pre) % DEPTH) + DEPTH) % DEPTH);
                end
                if (trig_k >= 0 && k == trig_k + post) begin
                    finished       = 1;
                    exp_done       = 1;
                    exp_done_cycle = c;
                end
                k++;
            end
        end
    endtask

    // Abort to IDLE, arm with the given config, scramble config inputs, play the stream
    task automatic run_capture(input string name, input int pre, input int post,
                               input logic [7:0] mask, input logic [7:0] value);
        bit e_done, e_trig;
        run_model(pre, post, mask, value);
        drive(0, 8'h00, 0, 0, 1);
        TrigMask = mask; TrigValue = value; PreLen = 4'(pre); PostLen = 4'(post);
        drive(0, 8'h00, 0, 1, 0);
        got_addr.delete(); got_data.delete();
        TrigMask = 8'($urandom); TrigValue = 8'($urandom);
        PreLen = 4'($urandom); PostLen = 4'($urandom);
        for (int c = 0; c < stim_s.size(); c++) begin
            drive(stim_s[c], stim_d[c], stim_f[c], stim_a[c], 0);
            e_done = exp_done && (c >= exp_done_cycle);
            e_trig = exp_trig && (c >= exp_trig_cycle);
            n_cmp++;
            if (Done !== e_done) begin
                n_err++; $display("FAIL %s done c=%0d: got %b expected %b", name, c, Done, e_done);
            end
            n_cmp++;
            if (Triggered !== e_trig) begin
                n_err++; $display("FAIL %s triggered c=%0d: got %b expected %b", name, c, Triggered, e_trig);
            end
            n_cmp++;
            if (Busy !== !e_done) begin
                n_err++; $display("FAIL %s busy c=%0d: got %b expected %b", name, c, Busy, !e_done);
            end
        end
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        n_cmp++;
        if (got_addr.size() != exp_addr.size()) begin
            n_err++; $display("FAIL %s write count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_cmp++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    n_err++;
                    $display("FAIL %s write %0d: got %0h@%0h expected %0h@%0h", name, i,
                             got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        if (exp_trig) begin
            n_cmp++;
            if (TrigAddr !== exp_trig_addr) begin
                n_err++; $display("FAIL %s trig_addr: got %0h expected %0h", name, TrigAddr, exp_trig_addr);
            end
            n_cmp++;
            if (StartAddr !== exp_start) begin
                n_err++; $display("FAIL %s start_addr: got %0h expected %0h", name, StartAddr, exp_start);
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        drive(1, 8'hFF, 1, 1, 0);
        n_cmp++; if (WrEn !== 1'b0)      begin n_err++; $display("FAIL reset wr_en: got %b expected 0", WrEn); end
        n_cmp++; if (WrAddr !== 4'h0)    begin n_err++; $display("FAIL reset wr_addr: got %0h expected 0", WrAddr); end
        n_cmp++; if (WrData !== 8'h00)   begin n_err++; $display("FAIL reset wr_data: got %0h expected 0", WrData); end
        n_cmp++; if (Busy !== 1'b0)      begin n_err++; $display("FAIL reset busy: got %b expected 0", Busy); end
        n_cmp++; if (Triggered !== 1'b0) begin n_err++; $display("FAIL reset triggered: got %b expected 0", Triggered); end
        n_cmp++; if (Done !== 1'b0)      begin n_err++; $display("FAIL reset done: got %b expected 0", Done); end
        n_cmp++; if (TrigAddr !== 4'h0)  begin n_err++; $display("FAIL reset trig_addr: got %0h expected 0", TrigAddr); end
        n_cmp++; if (StartAddr !== 4'h0) begin n_err++; $display("FAIL reset start_addr: got %0h expected 0", StartAddr); end
        Reset_n = 1'b1;
        drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_reset_mid_post();
        drive(0, 8'h00, 0, 0, 1);
        TrigMask = 8'hFF; TrigValue = 8'h22; PreLen = 4'd1; PostLen = 4'd5;
        drive(0, 8'h00, 0, 1, 0);
        drive(1, 8'h11, 0, 0, 0);
        drive(1, 8'h22, 0, 0, 0);
        drive(1, 8'h33, 0, 0, 0);
        n_cmp++; if (Triggered !== 1'b1) begin n_err++; $display("FAIL midpost triggered: got %b expected 1", Triggered); end
        Reset_n = 1'b0;
        drive(1, 8'h44, 0, 0, 0);
        Reset_n = 1'b1;
        n_cmp++;
        if ({WrEn, Busy, Triggered, Done} !== 4'b0000 || WrAddr !== 4'h0 || WrData !== 8'h00 ||
            TrigAddr !== 4'h0 || StartAddr !== 4'h0) begin
            n_err++;
            $display("FAIL midpost reset outputs: got en%b busy%b trg%b done%b a%0h d%0h ta%0h sa%0h expected all 0",
                     WrEn, Busy, Triggered, Done, WrAddr, WrData, TrigAddr, StartAddr);
        end
        TrigMask = 8'h00; PreLen = 4'd0; PostLen = 4'd5;
        drive(0, 8'h00, 0, 1, 0);
        drive(1, 8'h77, 0, 0, 0);
        n_cmp++;
        if (WrEn !== 1'b1 || WrAddr !== 4'h0 || WrData !== 8'h77) begin
            n_err++; $display("FAIL rearm first write: got en%b %0h@%0h expected en1 77@0", WrEn, WrData, WrAddr);
        end
    endtask

    task automatic test_basic();
        logic [7:0] seq [7] = '{8'h01, 8'h02, 8'hA5, 8'h04, 8'h05, 8'h06, 8'h07};
        stim_clear();
        foreach (seq[i]) stim_push(1, seq[i], 0, 0);
        run_capture("basic", 2, 3, 8'hFF, 8'hA5);
        n_cmp++; if (TrigAddr !== 4'd2)  begin n_err++; $display("FAIL basic trig_addr: got %0h expected 2", TrigAddr); end
        n_cmp++; if (StartAddr !== 4'd0) begin n_err++; $display("FAIL basic start_addr: got %0h expected 0", StartAddr); end
        n_cmp++; if (got_addr.size() != 6) begin n_err++; $display("FAIL basic writes: got %0d expected 6", got_addr.size()); end
    endtask

    task automatic test_wrap();
        stim_clear();
        for (int i = 0; i < 19; i++) stim_push(1, 8'(i), 0, 0);
        stim_push(1, 8'h5A, 0, 0);
        stim_push(1, 8'h61, 0, 0);
        stim_push(1, 8'h62, 0, 0);
        run_capture("wrap", 0, 1, 8'hFF, 8'h5A);
        n_cmp++; if (TrigAddr !== 4'd3)  begin n_err++; $display("FAIL wrap trig_addr: got %0h expected 3", TrigAddr); end
        n_cmp++; if (StartAddr !== 4'd3) begin n_err++; $display("FAIL wrap start_addr: got %0h expected 3", StartAddr); end
    endtask

    task automatic test_masked_force();
        stim_clear();
        stim_push(1, 8'h12, 0, 0);
        stim_push(1, 8'h34, 0, 0);
        stim_push(1, 8'h35, 0, 0);
        stim_push(1, 8'h36, 0, 0);
        stim_push(1, 8'h37, 0, 0);
        run_capture("masked", 0, 1, 8'h0F, 8'h05);
        n_cmp++; if (TrigAddr !== 4'd2) begin n_err++; $display("FAIL masked trig_addr: got %0h expected 2", TrigAddr); end
        stim_clear();
        stim_push(1, 8'h11, 0, 0);
        stim_push(0, 8'h33, 1, 0);
        stim_push(1, 8'h44, 0, 0);
        stim_push(1, 8'h55, 1, 0);
        stim_push(1, 8'h66, 0, 0);
        stim_push(1, 8'h77, 0, 0);
        run_capture("forced", 0, 1, 8'hFF, 8'h00);
        n_cmp++; if (TrigAddr !== 4'd2) begin n_err++; $display("FAIL forced trig_addr: got %0h expected 2", TrigAddr); end
    endtask

    task automatic test_priority();
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 1, 1);
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL arm_abort busy: got %b expected 0", Busy); end
        drive(1, 8'h12, 0, 0, 0);
        n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL arm_abort wr_en: got %b expected 0", WrEn); end
        TrigMask = 8'hFF; TrigValue = 8'h5A; PreLen = 4'd0; PostLen = 4'd2;
        drive(0, 8'h00, 0, 1, 0);
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL search busy: got %b expected 1", Busy); end
        drive(1, 8'h5A, 1, 0, 1);
        n_cmp++;
        if ({WrEn, Busy, Triggered, Done} !== 4'b0000) begin
            n_err++; $display("FAIL abort_search: got en%b busy%b trg%b done%b expected all 0", WrEn, Busy, Triggered, Done);
        end
        stim_clear();
        stim_push(1, 8'h11, 0, 0);
        stim_push(1, 8'h22, 0, 0);
        stim_push(1, 8'h33, 0, 1);
        stim_push(1, 8'h44, 0, 0);
        stim_push(0, 8'h00, 0, 1);
        stim_push(1, 8'h55, 0, 0);
        stim_push(1, 8'h66, 0, 0);
        run_capture("arm_in_post", 1, 3, 8'hFF, 8'h22);
    endtask

    task automatic test_gaps();
        stim_clear();
        for (int i = 0; i < 10; i++) stim_push((i % 2) == 0, 8'($urandom), 0, 0);
        run_capture("gaps", 0, 0, 8'h00, 8'h00);
        n_cmp++; if (got_addr.size() != 1) begin n_err++; $display("FAIL gaps writes: got %0d expected 1", got_addr.size()); end
    endtask

    task automatic test_random();
        int pre, post, sel;
        logic [7:0] mask, value;
        for (int it = 0; it < 12; it++) begin
            pre  = int'($urandom_range(0, 5));
            post = int'($urandom_range(0, 5));
            sel  = int'($urandom_range(0, 2));
            value = 8'($urandom);
            mask  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            stim_clear();
            for (int c = 0; c < 40; c++)
                stim_push($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 5) == 0) ? value : 8'($urandom),
                          $urandom_range(0, 15) == 0, 0);
            run_capture("random", pre, post, mask, value);
        end
    endtask

    initial begin
        Reset_n = 1'b0; DataIN = '0; StrobIN = 1'b0; Arm = 1'b0; Abort = 1'b0; ForceTrig = 1'b0;
        TrigMask = '0; TrigValue = '0; PreLen = '0; PostLen = '0;
        test_reset();
        test_reset_mid_post();
        test_basic();
        test_wrap();
        test_masked_force();
        test_priority();
        test_gaps();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
